// File: rtl/riscv_nn_thr_mem_arbiter.sv
// Shares the single data memory port between the LSU and the NN quantization
// threshold fetcher. Fixed LSU priority with an anti-starvation boost for QNT;
// responses are routed in order through an owner-ID FIFO.
module riscv_nn_thr_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req_i,
    input  logic [31:0] lsu_addr_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    input  logic        qnt_req_i,
    input  logic [31:0] qnt_addr_i,
    output logic        qnt_gnt_o,
    output logic        qnt_rvalid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        data_req_o,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        err_o
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, HOLD} state_e;
    typedef enum logic {OWN_LSU, OWN_QNT} owner_e;

    state_e                      state_q, state_d;
    owner_e                      owner_q, owner_d;
    owner_e                      owner;
    logic                        req;
    logic                        grant;
    logic                        push, pop;
    logic                        full;
    logic                        head_qnt;
    logic [MAX_OUTSTANDING-1:0]  fifo_q, fifo_d;
    logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic [SW-1:0]               starve_q, starve_d;
    logic                        err_q, err_d;

    assign full = (count_q == CW'(MAX_OUTSTANDING));

    // Arbitration FSM: pass-through in IDLE, owner frozen in HOLD until granted
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        req     = 1'b0;
        owner   = OWN_LSU;
        case (state_q)
            IDLE: begin
                if (!full) begin
                    req = lsu_req_i | qnt_req_i;
                end
                if (qnt_req_i && (!lsu_req_i || starve_q == SW'(STARVE_LIMIT))) begin
                    owner = OWN_QNT;
                end
                if (req && !data_gnt_i) begin
                    state_d = HOLD;
                    owner_d = owner;
                end
            end
            HOLD: begin
                req   = 1'b1;
                owner = owner_q;
                if (data_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant = req & data_gnt_i;

    // Memory-side request fields, muxed from the owner and zero when idle
    always_comb begin
        data_req_o   = req;
        data_addr_o  = '0;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_wdata_o = '0;
        if (req) begin
            if (owner == OWN_QNT) begin
                data_addr_o = qnt_addr_i;
                data_be_o   = '1;
            end else begin
                data_addr_o  = lsu_addr_i;
                data_we_o    = lsu_we_i;
                data_be_o    = lsu_be_i;
                data_wdata_o = lsu_wdata_i;
            end
        end
    end

    assign lsu_gnt_o = grant & (owner == OWN_LSU);
    assign qnt_gnt_o = grant & (owner == OWN_QNT);

    assign push     = grant;
    assign pop      = data_rvalid_i & (count_q != '0);
    assign head_qnt = fifo_q[rd_ptr_q];

    assign lsu_rvalid_o = pop & ~head_qnt;
    assign qnt_rvalid_o = pop & head_qnt;
    assign rsp_rdata_o  = pop ? data_rdata_i : '0;
    assign err_o        = err_q;

    // Owner FIFO bookkeeping, starvation counter and sticky error
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        err_d    = err_q | (data_rvalid_i & (count_q == '0));
        if (push) begin
            fifo_d[wr_ptr_q] = (owner == OWN_QNT);
            wr_ptr_d = (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (!qnt_req_i || qnt_gnt_o) begin
            starve_d = '0;
        end else if (lsu_gnt_o && starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= OWN_LSU;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

endmodule
